montgomery_mult_iter: RTL and testbench

Parametrised, bit-serial radix-2 Montgomery multiplier computing mult_result = x·y·2^-WORD_WIDTH mod m, with R = 2^WORD_WIDTH derived internally; there is no R input. It is the next-generation multiplier core for the RSA datapath, used by the modular-exponentiation controller. Relative to the current multiplier it adds:
- a start/busy/done handshake with back-to-back operation;
- operand validation with an error flag;
- guaranteed fully reduced output (< m).

---
 rtl/montgomery_mult_iter.sv | 100 ++++++++++
 tb/tb_montgomery_mult_iter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_mult_iter.sv
// rtl/montgomery_mult_iter.sv - bit-serial radix-2 Montgomery multiplier, x*y*2^-W mod m
module montgomery_mult_iter #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] m,
  input  logic [WORD_WIDTH-1:0] x,
  input  logic [WORD_WIDTH-1:0] y,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WORD_WIDTH-1:0] mult_result
);

  localparam int AW = WORD_WIDTH + 2;
  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, REDUCE} state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] xr;
  logic [WORD_WIDTH-1:0] yr;
  logic [WORD_WIDTH-1:0] mr;
  logic [AW-1:0]         acc;
  logic [CW-1:0]         cnt;

  logic [AW-1:0]         sum;
  logic [AW-1:0]         sum_odd;
  logic [AW-1:0]         acc_step;
  logic [WORD_WIDTH-1:0] diff;
  logic                  operands_ok;

  // acc < 2m and y < m keep acc + y + m below 4m, so WORD_WIDTH+2 bits never overflow
  always_comb begin
    sum      = acc + (xr[0] ? {2'b00, yr} : '0);
    sum_odd  = sum[0] ? (sum + {2'b00, mr}) : sum;
    acc_step = sum_odd >> 1;
    diff     = acc[WORD_WIDTH-1:0] - mr;
  end

  assign operands_ok = m[0] && (x < m) && (y < m);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      xr          <= '0;
      yr          <= '0;
      mr          <= '0;
      acc         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      mult_result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xr          <= x;
            yr          <= y;
            mr          <= m;
            mult_result <= '0;
            if (operands_ok) begin
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              error <= 1'b0;
              state <= ITER;
            end else begin
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end
        ITER: begin
          // x is consumed LSB first by shifting the registered copy
          acc <= acc_step;
          xr  <= xr >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= REDUCE;
          end
        end
        REDUCE: begin
          // diff is exact modulo 2^W because A - m < m whenever A >= m
          mult_result <= (acc >= {2'b00, mr}) ? diff : acc[WORD_WIDTH-1:0];
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult_iter.sv
// tb/tb_montgomery_mult_iter.sv - self-checking bench for montgomery_mult_iter at W=8 and W=32
module tb_montgomery_mult_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sel32 = 1'b0;
  logic [31:0] m_in = '0;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;

  logic        start8, start32;
  logic        busy8, done8, error8;
  logic        busy32, done32, error32;
  logic [7:0]  res8;
  logic [31:0] res32;
  logic        o_busy, o_done, o_error;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start8   = start & ~sel32;
  assign start32  = start & sel32;
  assign o_busy   = sel32 ? busy32 : busy8;
  assign o_done   = sel32 ? done32 : done8;
  assign o_error  = sel32 ? error32 : error8;
  assign o_result = sel32 ? res32 : {24'd0, res8};

  montgomery_mult_iter #(.WORD_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .m(m_in[7:0]), .x(x_in[7:0]), .y(y_in[7:0]),
    .busy(busy8), .done(done8), .error(error8), .mult_result(res8)
  );

  montgomery_mult_iter #(.WORD_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32),
    .m(m_in), .x(x_in), .y(y_in),
    .busy(busy32), .done(done32), .error(error32), .mult_result(res32)
  );

  // x*y*inverse(2)^w mod m, using the modular inverse of 2 for odd m
  function automatic logic [31:0] ref_mont(input int w, input longint unsigned mm,
                                           input longint unsigned xx, input longint unsigned yy);
    longint unsigned r;
    longint unsigned inv2;
    r    = (xx * yy) % mm;
    inv2 = (mm + 1) / 2;
    for (int i = 0; i < w; i++) r = (r * inv2) % mm;
    return r[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] mm, input logic [31:0] xx,
                        input logic [31:0] yy, output logic [31:0] res);
    int lat, bcnt, w;
    logic [31:0] exp;
    w = sel32 ? 32 : 8;
    exp = ref_mont(w, mm, xx, yy);
    m_in = mm; x_in = xx; y_in = yy; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!o_done && lat < 100) begin
      if (o_busy) bcnt++;
      tick();
      lat++;
    end
    res = o_result;
    check({tag, "_lat"}, lat, w + 1);
    check({tag, "_busy_cycles"}, bcnt, w + 1);
    check({tag, "_busy_at_done"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_result"}, o_result, exp);
    check({tag, "_error"}, {31'd0, o_error}, 32'd0);
    check({tag, "_lt_m"}, {31'd0, o_result < mm}, 32'd1);
  endtask

  initial begin
    logic [31:0] res, mm, xx, yy;
    logic [31:0] bx [3];
    logic [31:0] by [3];
    int lat, cnt;

    repeat (3) tick();
    check("rst_busy8", {31'd0, busy8}, 0);
    check("rst_done8", {31'd0, done8}, 0);
    check("rst_error8", {31'd0, error8}, 0);
    check("rst_res8", {24'd0, res8}, 0);
    check("rst_busy32", {31'd0, busy32}, 0);
    check("rst_res32", res32, 0);
    reset = 1'b1;
    tick();

    sel32 = 1'b0;
    run_op("basic", 13, 5, 7, res);
    check("basic_const", res, 1);

    // back-to-back with start held high through each done cycle
    bx[0] = 12; by[0] = 12; bx[1] = 0; by[1] = 11; bx[2] = 1; by[2] = 9;
    m_in = 13; x_in = bx[0]; y_in = by[0]; start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_done(lat);
      check("b2b_lat", lat, 9);
      check("b2b_result", o_result, ref_mont(8, 13, bx[k], by[k]));
      if (k < 2) begin
        x_in = bx[k+1]; y_in = by[k+1];
      end else begin
        start = 1'b0;
      end
      tick();
      check("b2b_done_single", {31'd0, o_done}, 0);
      check("b2b_busy_next", {31'd0, o_busy}, (k < 2) ? 1 : 0);
    end
    check("b2b_const0", ref_mont(8, 13, 12, 12), 3);
    cnt = 0;
    repeat (12) begin tick(); if (o_done) cnt++; end
    check("b2b_no_extra_done", cnt, 0);

    // invalid operands
    m_in = 14; x_in = 5; y_in = 7; start = 1'b1;
    tick();
    start = 1'b0;
    check("inv_even_done", {31'd0, o_done}, 1);
    check("inv_even_error", {31'd0, o_error}, 1);
    check("inv_even_result", o_result, 0);
    check("inv_even_busy", {31'd0, o_busy}, 0);
    tick();
    check("inv_done_pulse", {31'd0, o_done}, 0);
    check("inv_error_held", {31'd0, o_error}, 1);
    m_in = 13; x_in = 13; y_in = 7; start = 1'b1;
    tick();
    start = 1'b0;
    check("inv_xge_done", {31'd0, o_done}, 1);
    check("inv_xge_error", {31'd0, o_error}, 1);
    m_in = 13; x_in = 5; y_in = 7; start = 1'b1;
    tick();
    start = 1'b0;
    check("inv_clear_error", {31'd0, o_error}, 0);
    check("inv_clear_busy", {31'd0, o_busy}, 1);
    wait_done(lat);
    check("inv_recover_result", o_result, 1);

    // start during ITER is ignored
    m_in = 13; x_in = 5; y_in = 7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    x_in = 12; y_in = 12; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", lat + 3, 9);
    check("ign_result", o_result, 1);

    // reset mid-operation
    m_in = 13; x_in = 12; y_in = 12; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_busy", {31'd0, o_busy}, 0);
    check("abort_done", {31'd0, o_done}, 0);
    check("abort_result", o_result, 0);
    cnt = 0;
    repeat (20) begin tick(); if (o_done) cnt++; end
    check("abort_no_done", cnt, 0);

    sel32 = 1'b1;
    run_op("wide", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, res);
    check("wide_const", res, 1);

    for (int t = 0; t < 50; t++) begin
      sel32 = (t >= 25);
      if (sel32) mm = $urandom | 32'd1;
      else mm = $urandom_range(255, 1) | 32'd1;
      xx = $urandom % mm;
      yy = $urandom % mm;
      run_op(sel32 ? "rand32" : "rand8", mm, xx, yy, res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
